// File: rtl/he_lut_remap.sv
// LUT remap stage behind histogram equalization: captures the 256-entry table on an he_done rise, then remaps pixels.
// Optional macro HE_LUT_IDENTITY_INIT_EN: reset loads an identity table and starts in RUN.
module he_lut_remap #(
  parameter int IMAGE_WIDTH  = 660,
  parameter int IMAGE_HEIGHT = 440,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  he_done,
  input  logic [DATA_WIDTH-1:0] tbl_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pixel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pixel,
  output logic                  out_eol,
  output logic                  out_eof,
  output logic                  table_loaded,
  output logic                  frame_done
);

  localparam int unsigned DEPTH = 2 ** DATA_WIDTH;
  localparam int CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] lut [DEPTH];
  logic [DATA_WIDTH-1:0] cnt;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic                  he_done_q;
  logic                  start;
  logic                  load_start;
  logic                  in_fire;
  logic                  last_col;
  logic                  last_row;
  logic                  lut_we;
  logic [DATA_WIDTH-1:0] lut_addr;

  always_comb begin
    start      = he_done & ~he_done_q;
    // edges seen while already loading are ignored
    load_start = start & (state != LOAD);
    in_ready   = (state == RUN) & ~start & (~out_valid | out_ready);
    in_fire    = in_valid & in_ready;
    last_col   = (col == CW'(IMAGE_WIDTH - 1));
    last_row   = (row == RW'(IMAGE_HEIGHT - 1));
    lut_we     = load_start | (state == LOAD);
    lut_addr   = load_start ? '0 : cnt;
  end

  always_ff @(posedge clk) begin
`ifdef HE_LUT_IDENTITY_INIT_EN
    if (reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) lut[k] <= DATA_WIDTH'(k);
    end else
`endif
    if (lut_we) lut[lut_addr] <= tbl_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef HE_LUT_IDENTITY_INIT_EN
      state <= RUN;
`else
      state <= IDLE;
`endif
      cnt          <= '0;
      col          <= '0;
      row          <= '0;
      he_done_q    <= 1'b0;
      table_loaded <= 1'b0;
      out_valid    <= 1'b0;
      out_pixel    <= '0;
      out_eol      <= 1'b0;
      out_eof      <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      he_done_q  <= he_done;
      frame_done <= out_valid & out_ready & out_eof;

      if (in_fire) begin
        out_valid <= 1'b1;
        out_pixel <= lut[in_pixel];
        out_eol   <= last_col;
        out_eof   <= last_col & last_row;
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // in_fire and load_start are exclusive, so the counter clear cannot race the advance
      case (state)
        IDLE, RUN: begin
          if (load_start) begin
            state        <= LOAD;
            cnt          <= DATA_WIDTH'(1);
            table_loaded <= 1'b0;
            col          <= '0;
            row          <= '0;
          end
        end
        LOAD: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state        <= RUN;
            table_loaded <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_he_lut_remap.sv
// Bench for he_lut_remap: transaction-level reference model with per-cycle comparison plus literal checkpoints.
module tb_he_lut_remap;
  localparam int W = 66;
  localparam int H = 44;

  logic       clk = 1'b0;
  logic       reset, he_done, in_valid, in_ready, out_valid, out_ready;
  logic       out_eol, out_eof, table_loaded, frame_done;
  logic [7:0] tbl_data, in_pixel, out_pixel;

  always #5 clk = ~clk;

  he_lut_remap #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .he_done(he_done), .tbl_data(tbl_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_eol(out_eol), .out_eof(out_eof), .table_loaded(table_loaded),
    .frame_done(frame_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Reference model: the table as an array, the output register as a queue of pending entries,
  // the raster position as a single linear pixel index.
  typedef struct { int pix; bit eol; bit eof; } ent_t;
  ent_t m_q[$];
  int   m_lut [256];
  int   m_mode;       // 0 idle, 1 loading, 2 running
  int   m_cnt;
  int   m_pos;
  bit   m_loaded, m_hq, m_fd, m_init = 1'b0;
  int   fd_seen = 0;

  always @(negedge clk) begin
    bit   st, exp_rdy, oacc, iacc;
    ent_t e;
    st      = he_done && !m_hq && (m_mode != 1);
    exp_rdy = (m_mode == 2) && !st && (m_q.size() == 0 || out_ready);
    if (m_init) begin
      chk("out_valid", out_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("out_pixel", out_pixel, m_q[0].pix);
        chk("out_eol", out_eol, m_q[0].eol);
        chk("out_eof", out_eof, m_q[0].eof);
      end
      chk("in_ready", in_ready, exp_rdy);
      chk("table_loaded", table_loaded, m_loaded);
      chk("frame_done", frame_done, m_fd);
      if (frame_done === 1'b1) fd_seen++;
    end
    if (reset) begin
`ifdef HE_LUT_IDENTITY_INIT_EN
      m_mode = 2;
      for (int k = 0; k < 256; k++) m_lut[k] = k;
`else
      m_mode = 0;
`endif
      m_q.delete();
      m_cnt = 0; m_pos = 0; m_loaded = 0; m_hq = 0; m_fd = 0; m_init = 1;
    end else if (m_init) begin
      oacc = (m_q.size() != 0) && out_ready;
      iacc = in_valid && exp_rdy;
      m_fd = oacc && m_q[0].eof;
      if (oacc) void'(m_q.pop_front());
      if (iacc) begin
        e.pix = m_lut[in_pixel];
        e.eol = (m_pos % W) == W - 1;
        e.eof = (m_pos == W * H - 1);
        m_q.push_back(e);
        m_pos = (m_pos + 1) % (W * H);
      end
      if (st) begin
        m_lut[0] = tbl_data; m_mode = 1; m_cnt = 1; m_loaded = 0; m_pos = 0;
      end else if (m_mode == 1) begin
        m_lut[m_cnt] = tbl_data;
        if (m_cnt == 255) begin m_mode = 2; m_loaded = 1; end
        m_cnt++;
      end
      m_hq = he_done;
    end
  end

  function automatic logic [7:0] tval(input int kind, input int k);
    case (kind)
      0:       return 8'(255 - k);
      1:       return 8'(k);
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Streams a complete 256-entry table starting with an he_done rise.
  task automatic stream_table(input int kind, input bit chk_rdy);
    int low = 0;
    for (int k = 0; k < 256; k++) begin
      he_done = 1'b1; tbl_data = tval(kind, k);
      #1;
      if (in_ready === 1'b0) low++;
      if (k == 255) chk("tl_before_256", table_loaded, 0);
      tick();
    end
    chk("tl_after_256", table_loaded, 1);
    if (chk_rdy) chk("rdy_low_cycles", low, 256);
    he_done = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  task automatic one_pixel(input int p, input int exp, input string name);
    in_valid = 1'b1; in_pixel = 8'(p);
    tick();
    in_valid = 1'b0;
    chk({name, "_valid"}, out_valid, 1);
    chk(name, out_pixel, exp);
    tick();
  endtask

  // Streams pixels with out_ready high until `goal` are accepted; optional 5-cycle stall.
  task automatic run_pixels(input int goal, input int stall_at);
    int acc = 0, cyc = 0;
    logic [7:0] held = '0;
    while (acc < goal && cyc < goal + 200) begin
      in_valid = 1'b1; in_pixel = 8'($urandom);
      out_ready = !(cyc >= stall_at && cyc < stall_at + 5);
      #1;
      if (cyc == stall_at) held = out_pixel;
      if (!out_ready) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_hold", out_pixel, held);
      end
      if (in_ready) acc++;
      tick();
      cyc++;
    end
    chk("run_pixels_done", acc, goal);
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1; he_done = 1'b0; tbl_data = '0; in_valid = 1'b0;
    in_pixel = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_table_loaded", table_loaded, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_done", frame_done, 0);
`ifdef HE_LUT_IDENTITY_INIT_EN
    chk("rst_in_ready", in_ready, 1);
`else
    chk("rst_in_ready", in_ready, 0);
`endif
    tick();

    // inverted table, then literal lookups
    stream_table(0, 1'b1);
    one_pixel(0, 255, "lut0");
    one_pixel(17, 238, "lut17");
    one_pixel(255, 0, "lut255");

    // remainder of the frame with a mid-line stall; eof must land on the final pixel
    fd_seen = 0;
    run_pixels(W * H - 3, 100);
    repeat (3) tick();
    chk("frame_done_pulses", fd_seen, 1);

    // reload with identity table at pixel 1000 of the next frame
    run_pixels(1000, 1 << 30);
    in_valid = 1'b1;
    stream_table(1, 1'b1);
    one_pixel(200, 200, "reload200");
    chk("reload_col0_eol", out_eol, 0);
    for (int k = 1; k < W; k++) begin
      in_valid = 1'b1; in_pixel = 8'(k);
      tick();
    end
    in_valid = 1'b0;
    chk("reload_eol_at_w", out_eol, 1);
    chk("reload_eol_pix", out_pixel, W - 1);
    tick();

    // random table and random handshakes
    stream_table(2, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_pixel  = 8'($urandom);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();

    // reset after 100 table entries
    for (int k = 0; k < 100; k++) begin
      he_done = 1'b1; tbl_data = 8'($urandom);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; he_done = 1'b0;
    #1;
    chk("midload_rst_tl", table_loaded, 0);
`ifdef HE_LUT_IDENTITY_INIT_EN
    chk("midload_rst_rdy", in_ready, 1);
    tick();
    one_pixel(77, 77, "ident77");
`else
    chk("midload_rst_rdy", in_ready, 0);
    tick();
    chk("midload_rst_rdy_later", in_ready, 0);
`endif
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
